// File: rtl/aes_pkg.sv
// Shared types for the AES ciphertext serializer.
// The 4x4 byte state, the streaming FSM states and the per-row word packing.
package aes_pkg;

    typedef logic [3:0][3:0][7:0] aes_state_t;

    typedef enum logic {
        IDLE,
        SEND
    } ser_state_t;

    localparam int NUM_WORDS = 4;

    // Byte [r][0] lands in bits 31:24
    function automatic logic [31:0] pack_row(
        input aes_state_t s,
        input logic [1:0] r
    );
        return {s[r][0], s[r][1], s[r][2], s[r][3]};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/aes_ct_serializer.sv
// Captures each AES-128 ciphertext on completion and streams it as four words.
// AES_CT_FAULT_SQUASH_EN: CED-flagged blocks are counted but never streamed.
module aes_ct_serializer
    import aes_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  aes_state_t       ciphertext,
    input  logic             done,
    input  logic             fault_detected,
    output logic [31:0]      out_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             out_fault,
    output logic             busy,
    output logic             overrun,
    output logic [CNT_W-1:0] block_cnt,
    output logic [CNT_W-1:0] fault_cnt
);

    ser_state_t state;
    aes_state_t ct_buf;
    logic [1:0] idx;
    logic [1:0] idx_nxt;
    logic       done_q;
    logic       evt;
    logic       capture;
    logic       squash;
    logic       last_word;

`ifdef AES_CT_FAULT_SQUASH_EN
    assign squash = fault_detected;
`else
    assign squash = 1'b0;
`endif

    assign evt       = done && !done_q;
    assign capture   = evt && (state == IDLE);
    assign idx_nxt   = idx + 2'd1;
    assign last_word = (idx == 2'(NUM_WORDS - 1));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            ct_buf    <= '0;
            idx       <= '0;
            done_q    <= 1'b0;
            out_word  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_fault <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            done_q <= done;
            unique case (state)
                IDLE: begin
                    if (capture && !squash) begin
                        state     <= SEND;
                        ct_buf    <= ciphertext;
                        idx       <= '0;
                        out_word  <= pack_row(ciphertext, 2'd0);
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        out_fault <= fault_detected;
                        busy      <= 1'b1;
                    end
                end
                SEND: begin
                    // A completion while streaming, even on the final beat, is lost
                    if (evt) begin
                        overrun <= 1'b1;
                    end
                    if (out_ready) begin
                        if (last_word) begin
                            state     <= IDLE;
                            idx       <= '0;
                            out_word  <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_fault <= 1'b0;
                            busy      <= 1'b0;
                        end else begin
                            idx      <= idx_nxt;
                            out_word <= pack_row(ct_buf, idx_nxt);
                            out_last <= (idx_nxt == 2'(NUM_WORDS - 1));
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_block_cnt (
        .clock(clock),
        .reset(reset),
        .inc  (capture),
        .count(block_cnt)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_fault_cnt (
        .clock(clock),
        .reset(reset),
        .inc  (capture && fault_detected),
        .count(fault_cnt)
    );

endmodule

// File: tb/tb_aes_ct_serializer.sv
// Directed bench for aes_ct_serializer using the FIPS-197 AES-128 vector.
// Fault expectations follow AES_CT_FAULT_SQUASH_EN when it is defined.
module tb_aes_ct_serializer;
    import aes_pkg::*;

    localparam int CNT_W = 16;

    logic             clock;
    logic             reset;
    aes_state_t       ciphertext;
    logic             done;
    logic             fault_detected;
    logic [31:0]      out_word;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             out_fault;
    logic             busy;
    logic             overrun;
    logic [CNT_W-1:0] block_cnt;
    logic [CNT_W-1:0] fault_cnt;

    int checks;
    int failures;

    logic [31:0] got_w[4];
    logic        got_l[4];
    logic        got_f[4];
    int          nhs;
    int          stall_err;
    int          stall_cyc;

    logic [31:0] exp_w[4];

    aes_ct_serializer #(
        .CNT_W(CNT_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ciphertext    (ciphertext),
        .done          (done),
        .fault_detected(fault_detected),
        .out_word      (out_word),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .out_fault     (out_fault),
        .busy          (busy),
        .overrun       (overrun),
        .block_cnt     (block_cnt),
        .fault_cnt     (fault_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_ct(input logic [127:0] v);
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                ciphertext[k][j] = v[127 - 8 * (4 * k + j) -: 8];
            end
        end
    endtask

    task automatic pulse_done(input logic f);
        fault_detected = f;
        done = 1'b1;
        tick();
        done = 1'b0;
        fault_detected = 1'b0;
    endtask

    // Accept n words; toggle selects ready pattern 1,0,0,1,...
    task automatic drain(input bit toggle, input int n);
        int          cyc;
        bit          stalled;
        logic [31:0] hw;
        logic        hl;
        nhs = 0;
        stall_err = 0;
        stall_cyc = 0;
        stalled = 0;
        cyc = 0;
        hw = '0;
        hl = 1'b0;
        while (nhs < n && cyc < 60) begin
            out_ready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (out_valid) begin
                if (stalled && (out_word !== hw || out_last !== hl)) begin
                    stall_err++;
                end
                if (out_ready) begin
                    got_w[nhs] = out_word;
                    got_l[nhs] = out_last;
                    got_f[nhs] = out_fault;
                    nhs++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    stall_cyc++;
                    hw = out_word;
                    hl = out_last;
                end
            end
            cyc++;
            tick();
        end
        out_ready = 1'b0;
        chk("handshake_budget", 32'(nhs), 32'(n));
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        done = 1'b0;
        fault_detected = 1'b0;
        out_ready = 1'b0;
        ciphertext = '0;
        exp_w[0] = 32'h69c4e0d8;
        exp_w[1] = 32'h6a7b0430;
        exp_w[2] = 32'hd8cdb780;
        exp_w[3] = 32'h70b4c55a;

        repeat (3) tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_word", out_word, 32'd0);
        chk("rst_block_cnt", 32'(block_cnt), 32'd0);
        chk("rst_fault_cnt", 32'(fault_cnt), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b1;
        tick();

        // FIPS-197 block, ready high
        load_ct(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        pulse_done(1'b0);
        chk("t1_latency_valid", 32'(out_valid), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        drain(1'b0, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_word%0d", i), got_w[i], exp_w[i]);
            chk($sformatf("t1_last%0d", i), 32'(got_l[i]), 32'(i == 3));
            chk($sformatf("t1_fault%0d", i), 32'(got_f[i]), 32'd0);
        end
        chk("t1_valid_drop", 32'(out_valid), 32'd0);
        chk("t1_busy_drop", 32'(busy), 32'd0);
        chk("t1_block_cnt", 32'(block_cnt), 32'd1);
        chk("t1_fault_cnt", 32'(fault_cnt), 32'd0);

        // Same vector, ready toggling 1,0,0,1
        tick();
        pulse_done(1'b0);
        drain(1'b1, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_word%0d", i), got_w[i], exp_w[i]);
            chk($sformatf("t2_last%0d", i), 32'(got_l[i]), 32'(i == 3));
        end
        chk("t2_stall_hold", 32'(stall_err), 32'd0);
        chk("t2_stalls_seen", 32'(stall_cyc > 0), 32'd1);
        out_ready = 1'b1;
        tick();
        tick();
        chk("t2_no_extra_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        chk("t2_block_cnt", 32'(block_cnt), 32'd2);

        // done held high for 20 cycles
        out_ready = 1'b1;
        done = 1'b1;
        repeat (20) tick();
        done = 1'b0;
        out_ready = 1'b0;
        tick();
        chk("t3_block_cnt", 32'(block_cnt), 32'd3);
        chk("t3_idle", 32'(out_valid), 32'd0);
        chk("t3_overrun", 32'(overrun), 32'd0);

        // Second completion while word 1 is stalled
        pulse_done(1'b0);
        drain(1'b0, 1);
        chk("t4_w0", got_w[0], exp_w[0]);
        load_ct(~128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        pulse_done(1'b0);
        chk("t4_overrun", 32'(overrun), 32'd1);
        chk("t4_held_word", out_word, exp_w[1]);
        chk("t4_block_cnt", 32'(block_cnt), 32'd4);
        drain(1'b0, 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t4_word%0d", i + 1), got_w[i], exp_w[i + 1]);
        end
        chk("t4_valid_drop", 32'(out_valid), 32'd0);
        load_ct(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        tick();

        // CED-flagged block
        pulse_done(1'b1);
`ifdef AES_CT_FAULT_SQUASH_EN
        chk("t5_squash_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        repeat (6) tick();
        chk("t5_squash_valid_late", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
`else
        drain(1'b0, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t5_word%0d", i), got_w[i], exp_w[i]);
            chk($sformatf("t5_fault%0d", i), 32'(got_f[i]), 32'd1);
        end
`endif
        chk("t5_fault_cnt", 32'(fault_cnt), 32'd1);
        chk("t5_block_cnt", 32'(block_cnt), 32'd5);
        tick();

        // Reset during word 2
        pulse_done(1'b0);
        drain(1'b0, 2);
        chk("t6_at_word2", out_word, exp_w[2]);
        reset = 1'b0;
        tick();
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_block_cnt", 32'(block_cnt), 32'd0);
        chk("t6_fault_cnt", 32'(fault_cnt), 32'd0);
        chk("t6_overrun", 32'(overrun), 32'd0);
        reset = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("t6_no_partial", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        pulse_done(1'b0);
        drain(1'b0, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t6_word%0d", i), got_w[i], exp_w[i]);
        end
        chk("t6_block_cnt_after", 32'(block_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
